// File: rtl/pipe_ctrl.sv
// Pipeline control: resolves memory-stall / load-use / flush priority into
// per-stage enables, runs a memory-stall watchdog, and (with PIPE_PERF_CNT_EN) keeps perf counters.
module pipe_ctrl #(
  parameter int unsigned STALL_LIMIT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             LoadUse_i,
  input  logic             Flush_i,
  input  logic             MemStall_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXBubble_o,
  output logic             EXMEMWrite_o,
  output logic             MEMWBBubble_o,
  output logic             Timeout_o,
  output logic [CNT_W-1:0] LuCnt_o,
  output logic [CNT_W-1:0] MemCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] scnt_q, scnt_d;
  logic        timeout_q, timeout_d;
  logic        rule_mem, rule_lu, rule_fl;

  always_comb begin
    PCWrite_o     = 1'b1;
    IFIDWrite_o   = 1'b1;
    EXMEMWrite_o  = 1'b1;
    IFIDFlush_o   = 1'b0;
    IDEXBubble_o  = 1'b0;
    MEMWBBubble_o = 1'b0;
    rule_mem      = 1'b0;
    rule_lu       = 1'b0;
    rule_fl       = 1'b0;
    if (rst_i) begin
      PCWrite_o     = 1'b0;
      IFIDWrite_o   = 1'b0;
      EXMEMWrite_o  = 1'b0;
      IFIDFlush_o   = 1'b1;
      IDEXBubble_o  = 1'b1;
      MEMWBBubble_o = 1'b1;
    end else if (state_q == HALT) begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      EXMEMWrite_o = 1'b0;
    end else if (MemStall_i) begin
      PCWrite_o     = 1'b0;
      IFIDWrite_o   = 1'b0;
      EXMEMWrite_o  = 1'b0;
      MEMWBBubble_o = 1'b1;
      rule_mem      = 1'b1;
    end else if (LoadUse_i) begin
      // branch operands are not valid yet, so a concurrent flush is dropped
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXBubble_o = 1'b1;
      rule_lu      = 1'b1;
    end else if (Flush_i) begin
      IFIDFlush_o = 1'b1;
      rule_fl     = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN: begin
        if (MemStall_i) begin
          state_d = MEMWAIT;
          scnt_d  = 16'd1;
        end
      end
      MEMWAIT: begin
        if (!MemStall_i) begin
          state_d = RUN;
          scnt_d  = '0;
        end else if (scnt_q == 16'(STALL_LIMIT - 1)) begin
          state_d   = HALT;
          timeout_d = 1'b1;
        end else begin
          scnt_d = scnt_q + 16'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      scnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout_o = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, mem_cnt_q, fl_cnt_q;

  // rule flags are already zero during reset and HALT
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      if (rule_lu)  lu_cnt_q  <= lu_cnt_q + 1'b1;
      if (rule_mem) mem_cnt_q <= mem_cnt_q + 1'b1;
      if (rule_fl)  fl_cnt_q  <= fl_cnt_q + 1'b1;
    end
  end

  assign LuCnt_o    = lu_cnt_q;
  assign MemCnt_o   = mem_cnt_q;
  assign FlushCnt_o = fl_cnt_q;
`else
  logic unused_rules;
  assign unused_rules = ^{rule_lu, rule_mem, rule_fl};
  assign LuCnt_o      = '0;
  assign MemCnt_o     = '0;
  assign FlushCnt_o   = '0;
`endif

endmodule
